// File: rtl/fourfunc_request_driver_if.sv
// Request, engine and response signal bundle for the four-function request driver.
interface fourfunc_request_driver_if #(
    parameter int unsigned F_WIDTH    = 8,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Host request channel
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_func;
    logic [F_WIDTH-1:0]   req_x;
    logic [TAG_WIDTH-1:0] req_tag;

    // Engine start/busy channel
    logic                 eng_start;
    logic [1:0]           eng_func;
    logic [F_WIDTH-1:0]   eng_x;
    logic                 eng_busy;
    logic [1:0]           eng_ipart;
    logic [F_WIDTH-1:0]   eng_fpart;

    // Host response channel
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_ipart;
    logic [F_WIDTH-1:0]   rsp_fpart;
    logic [TAG_WIDTH-1:0] rsp_tag;
    logic                 rsp_err;

    logic [CNT_W-1:0]     fifo_count;

    // Driver side
    modport master (
        input  req_valid, req_func, req_x, req_tag,
        output req_ready,
        output eng_start, eng_func, eng_x,
        input  eng_busy, eng_ipart, eng_fpart,
        output rsp_valid, rsp_ipart, rsp_fpart, rsp_tag, rsp_err,
        input  rsp_ready,
        output fifo_count
    );

    // Host and engine side
    modport slave (
        output req_valid, req_func, req_x, req_tag,
        input  req_ready,
        input  eng_start, eng_func, eng_x,
        output eng_busy, eng_ipart, eng_fpart,
        input  rsp_valid, rsp_ipart, rsp_fpart, rsp_tag, rsp_err,
        output rsp_ready,
        input  fifo_count
    );
endinterface

// File: rtl/fourfunc_request_driver.sv
// Buffers tagged requests, runs them one at a time on the Taylor-series engine,
// and returns results (or timeout errors) on a valid/ready response channel.
module fourfunc_request_driver #(
    parameter int unsigned F_WIDTH     = 8,
    parameter int unsigned TAG_WIDTH   = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned BUSY_WAIT   = 3,
    parameter int unsigned TIMEOUT     = 63,
    parameter int unsigned TO_WIDTH    = 6
) (
    input logic                      clk,
    input logic                      rst,
    fourfunc_request_driver_if.master bus
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_RESPOND
    } state_e;

    state_e               state_q, state_d;
    logic [INIT_W-1:0]    init_cnt_q, init_cnt_d;
    logic [TO_WIDTH-1:0]  to_cnt_q, to_cnt_d;

    logic [1:0]           mem_func_q [FIFO_DEPTH];
    logic [F_WIDTH-1:0]   mem_x_q    [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0] mem_tag_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 req_ready_q;
    logic                 push, pop;

    logic                 eng_start_q;
    logic [1:0]           eng_func_q, eng_func_d;
    logic [F_WIDTH-1:0]   eng_x_q, eng_x_d;
    logic                 rsp_valid_q;
    logic [1:0]           rsp_ipart_q, rsp_ipart_d;
    logic [F_WIDTH-1:0]   rsp_fpart_q, rsp_fpart_d;
    logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
    logic                 rsp_err_q, rsp_err_d;

    assign push    = bus.req_valid && req_ready_q;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Next state, engine operand load and result capture
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        to_cnt_d    = to_cnt_q;
        pop         = 1'b0;
        eng_func_d  = eng_func_q;
        eng_x_d     = eng_x_q;
        rsp_ipart_d = rsp_ipart_q;
        rsp_fpart_d = rsp_fpart_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) state_d = S_IDLE;
                else init_cnt_d = init_cnt_q + INIT_W'(1);
            end
            S_IDLE: begin
                if ((count_q != '0) && !rsp_valid_q) begin
                    pop        = 1'b1;
                    eng_func_d = mem_func_q[rd_ptr_q];
                    eng_x_d    = mem_x_q[rd_ptr_q];
                    rsp_tag_d  = mem_tag_q[rd_ptr_q];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.eng_busy) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT_DONE;
                end else if (to_cnt_q == TO_WIDTH'(BUSY_WAIT - 1)) begin
                    rsp_ipart_d = '0;
                    rsp_fpart_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESPOND;
                end else begin
                    to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!bus.eng_busy) begin
                    rsp_ipart_d = bus.eng_ipart;
                    rsp_fpart_d = bus.eng_fpart;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESPOND;
                end else if (to_cnt_q == TO_WIDTH'(TIMEOUT - 1)) begin
                    rsp_ipart_d = '0;
                    rsp_fpart_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESPOND;
                end else begin
                    to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                end
            end
            S_RESPOND: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // State, counters, FIFO pointers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            to_cnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_ready_q <= 1'b1;
            eng_start_q <= 1'b0;
            eng_func_q  <= '0;
            eng_x_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ipart_q <= '0;
            rsp_fpart_q <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            to_cnt_q    <= to_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_d;
            req_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
            eng_start_q <= (state_d == S_ISSUE);
            eng_func_q  <= eng_func_d;
            eng_x_q     <= eng_x_d;
            rsp_valid_q <= (state_d == S_RESPOND);
            rsp_ipart_q <= rsp_ipart_d;
            rsp_fpart_q <= rsp_fpart_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_func_q[wr_ptr_q] <= bus.req_func;
            mem_x_q[wr_ptr_q]    <= bus.req_x;
            mem_tag_q[wr_ptr_q]  <= bus.req_tag;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.eng_start  = eng_start_q;
    assign bus.eng_func   = eng_func_q;
    assign bus.eng_x      = eng_x_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_ipart  = rsp_ipart_q;
    assign bus.rsp_fpart  = rsp_fpart_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_fourfunc_request_driver.sv
// Scoreboard bench for fourfunc_request_driver with a behavioural engine model.
module tb_fourfunc_request_driver;
    localparam int unsigned F_WIDTH    = 8;
    localparam int unsigned TAG_WIDTH  = 4;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef struct packed {
        logic [1:0] ip;
        logic [7:0] fp;
        logic [3:0] tag;
        logic       err;
    } rsp_t;

    typedef struct packed {
        logic [1:0] f;
        logic [7:0] x;
    } iss_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fourfunc_request_driver_if #(.F_WIDTH(F_WIDTH), .TAG_WIDTH(TAG_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) ifc ();

    fourfunc_request_driver #(
        .F_WIDTH(F_WIDTH), .TAG_WIDTH(TAG_WIDTH), .FIFO_DEPTH(FIFO_DEPTH),
        .INIT_CYCLES(2), .BUSY_WAIT(3), .TIMEOUT(63), .TO_WIDTH(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    rsp_t exp_q[$];
    iss_t iss_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   eng_mode = 0;   // 0 normal, 1 busy never rises, 2 busy stuck high
    int   eng_len  = 0;   // busy length in normal mode, 0 = random
    int   rdy_mode = 0;   // 0 always ready, 1 random, 2 driven by main sequence

    task automatic check_ok(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected response from the engine's behaviour: normal engine returns
    // ipart=func, fpart=x+0x1A; any timeout returns zeroed fields with err.
    function automatic rsp_t ref_rsp(input int mode, input logic [1:0] f, input logic [7:0] x, input logic [3:0] t);
        rsp_t r;
        r.tag = t;
        if (mode == 0) begin
            r.ip = f; r.fp = x + 8'h1A; r.err = 1'b0;
        end else begin
            r.ip = 2'b00; r.fp = 8'h00; r.err = 1'b1;
        end
        return r;
    endfunction

    task automatic push_req(input logic [1:0] f, input logic [7:0] x, input logic [3:0] t);
        bit got = 1'b0;
        ifc.req_valid = 1'b1; ifc.req_func = f; ifc.req_x = x; ifc.req_tag = t;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (ifc.req_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            check_ok("push_timeout", 1'b0, 32'(t), 32'(t));
            ifc.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        exp_q.push_back(ref_rsp(eng_mode, f, x, t));
        iss_q.push_back({f, x});
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || iss_q.size() != 0) && n < limit) begin
            @(negedge clk); n++;
        end
        check_ok("drain", exp_q.size() == 0 && iss_q.size() == 0, 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Releases reset with a request already waiting; start must wait out INIT.
    task automatic release_and_issue(input logic [1:0] f, input logic [7:0] x, input logic [3:0] t);
        @(posedge clk); #1;
        rst = 1'b0;
        ifc.req_valid = 1'b1; ifc.req_func = f; ifc.req_x = x; ifc.req_tag = t;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        exp_q.push_back(ref_rsp(eng_mode, f, x, t));
        iss_q.push_back({f, x});
        @(negedge clk); check_ok("init_no_start_1", ifc.eng_start == 1'b0, 32'(ifc.eng_start), 32'd0);
        @(negedge clk); check_ok("init_no_start_2", ifc.eng_start == 1'b0, 32'(ifc.eng_start), 32'd0);
        @(negedge clk); check_ok("first_start", ifc.eng_start == 1'b1, 32'(ifc.eng_start), 32'd1);
    endtask

    task automatic run_engine(input iss_t e);
        int len;
        int n;
        if (eng_mode == 0) begin
            len = (eng_len != 0) ? eng_len : int'($urandom_range(2, 40));
            ifc.eng_busy = 1'b1; ifc.eng_ipart = 2'($urandom); ifc.eng_fpart = 8'($urandom);
            for (int i = 1; i < len; i++) begin
                @(posedge clk); #1;
                if (rst) begin ifc.eng_busy = 1'b0; return; end
                check_ok("eng_hold", ifc.eng_func == e.f && ifc.eng_x == e.x && !ifc.eng_start,
                         32'({ifc.eng_start, ifc.eng_func, ifc.eng_x}), 32'({1'b0, e.f, e.x}));
                ifc.eng_fpart = 8'($urandom);
            end
            @(posedge clk); #1;
            ifc.eng_busy = 1'b0;
            if (rst) return;
            ifc.eng_ipart = e.f; ifc.eng_fpart = e.x + 8'h1A;
            @(posedge clk); #1;
            ifc.eng_ipart = 2'($urandom); ifc.eng_fpart = 8'($urandom);
        end else begin
            ifc.eng_busy = (eng_mode == 2);
            n = 0;
            while (n < 200) begin
                @(posedge clk); #1;
                if (rst) begin ifc.eng_busy = 1'b0; return; end
                n++;
                if (ifc.rsp_valid) break;
            end
            ifc.eng_busy = 1'b0;
            if (eng_mode == 1)
                check_ok("nobusy_latency", n >= 3 && n <= 5, 32'(n), 32'd4);
            else
                check_ok("stuck_latency", n >= 63 && n <= 66, 32'(n), 32'd65);
        end
    endtask

    // Engine model: reacts to start pulses, checks the operand against issue order
    initial begin
        iss_t e;
        ifc.eng_busy = 1'b0; ifc.eng_ipart = '0; ifc.eng_fpart = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin ifc.eng_busy = 1'b0; continue; end
            if (ifc.eng_start) begin
                check_ok("start_while_busy", ifc.eng_busy == 1'b0, 32'(ifc.eng_busy), 32'd0);
                if (iss_q.size() == 0) begin
                    check_ok("unexpected_start", 1'b0, 32'({ifc.eng_func, ifc.eng_x}), 32'd0);
                end else begin
                    e = iss_q.pop_front();
                    check_ok("issue_operand", ifc.eng_func == e.f && ifc.eng_x == e.x,
                             32'({ifc.eng_func, ifc.eng_x}), 32'(e));
                    run_engine(e);
                end
            end
        end
    end

    // Response consumer
    initial begin
        ifc.rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) ifc.rsp_ready = 1'b1;
            else if (rdy_mode == 1) ifc.rsp_ready = ($urandom_range(0, 99) < 60);
        end
    end

    // Response monitor and scoreboard
    initial begin
        rsp_t e;
        rsp_t got;
        forever begin
            @(negedge clk);
            if (!rst && ifc.rsp_valid) begin
                check_ok("start_during_rsp", ifc.eng_start == 1'b0, 32'(ifc.eng_start), 32'd0);
                if (ifc.rsp_ready) begin
                    got = {ifc.rsp_ipart, ifc.rsp_fpart, ifc.rsp_tag, ifc.rsp_err};
                    if (exp_q.size() == 0) begin
                        check_ok("unexpected_rsp", 1'b0, 32'(got), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_ok("rsp", got == e, 32'(got), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ifc.req_valid = 1'b0; ifc.req_func = '0; ifc.req_x = '0; ifc.req_tag = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_ok("rst_eng_start",  ifc.eng_start  == 1'b0, 32'(ifc.eng_start), 32'd0);
        check_ok("rst_eng_func",   ifc.eng_func   == 2'b0, 32'(ifc.eng_func), 32'd0);
        check_ok("rst_eng_x",      ifc.eng_x      == 8'h0, 32'(ifc.eng_x), 32'd0);
        check_ok("rst_rsp",        {ifc.rsp_valid, ifc.rsp_ipart, ifc.rsp_fpart, ifc.rsp_tag, ifc.rsp_err} == '0,
                 32'({ifc.rsp_valid, ifc.rsp_ipart, ifc.rsp_fpart, ifc.rsp_tag, ifc.rsp_err}), 32'd0);
        check_ok("rst_fifo_count", ifc.fifo_count == '0, 32'(ifc.fifo_count), 32'd0);
        check_ok("rst_req_ready",  ifc.req_ready  == 1'b1, 32'(ifc.req_ready), 32'd1);

        // Single request with nominal 33-cycle engine
        eng_mode = 0; eng_len = 33;
        release_and_issue(2'b01, 8'h40, 4'd3);
        drain(300);

        // Back-to-back: fill the FIFO while the engine works
        push_req(2'b00, 8'h10, 4'd0);
        n = 0;
        while (!ifc.eng_busy && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) push_req(2'(i), 8'(8'h20 + i), 4'(i));
        @(negedge clk);
        check_ok("full_count", ifc.fifo_count == 3'd4, 32'(ifc.fifo_count), 32'd4);
        check_ok("full_ready", ifc.req_ready == 1'b0, 32'(ifc.req_ready), 32'd0);
        @(posedge clk); #1;
        push_req(2'b11, 8'hF0, 4'd5);
        drain(600);

        // Response backpressure
        rdy_mode = 2; ifc.rsp_ready = 1'b0; eng_len = 10;
        push_req(2'b10, 8'h33, 4'hA);
        push_req(2'b01, 8'h44, 4'hB);
        push_req(2'b11, 8'h55, 4'hC);
        n = 0;
        while (!ifc.rsp_valid && n < 100) begin @(negedge clk); n++; end
        check_ok("bp_rsp_valid", ifc.rsp_valid == 1'b1, 32'(ifc.rsp_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_ok("bp_hold", {ifc.rsp_ipart, ifc.rsp_fpart, ifc.rsp_tag, ifc.rsp_err} == exp_q[0] && ifc.rsp_valid,
                     32'({ifc.rsp_ipart, ifc.rsp_fpart, ifc.rsp_tag, ifc.rsp_err}), 32'(exp_q[0]));
            check_ok("bp_fifo_count", ifc.fifo_count == 3'd2, 32'(ifc.fifo_count), 32'd2);
        end
        @(posedge clk); #1;
        ifc.rsp_ready = 1'b1; rdy_mode = 0;
        drain(300);

        // Busy never rises, then a normal request
        eng_mode = 1;
        push_req(2'b10, 8'h11, 4'd5);
        drain(100);
        eng_mode = 0;
        push_req(2'b11, 8'h22, 4'd6);
        drain(100);

        // Busy stuck high, then a normal request
        eng_mode = 2;
        push_req(2'b01, 8'h77, 4'd7);
        drain(300);
        eng_mode = 0;
        push_req(2'b00, 8'h88, 4'd8);
        drain(100);

        // Reset during WAIT_DONE drops everything
        eng_len = 33;
        push_req(2'b01, 8'h01, 4'd9);
        push_req(2'b10, 8'h02, 4'd10);
        push_req(2'b11, 8'h03, 4'd11);
        n = 0;
        while (!ifc.eng_busy && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        iss_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_ok("midrst_fifo_count", ifc.fifo_count == '0, 32'(ifc.fifo_count), 32'd0);
        check_ok("midrst_rsp_valid", ifc.rsp_valid == 1'b0, 32'(ifc.rsp_valid), 32'd0);
        release_and_issue(2'b10, 8'hC4, 4'd12);
        drain(300);

        // Randomized traffic with random engine latency and consumer stalls
        eng_len = 0; rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            push_req(2'($urandom), 8'($urandom), 4'($urandom));
            repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
        end
        drain(4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fourfunc_request_driver.md
Name: fourfunc_request_driver

Overview:
- Host-side initiator for the four-function Taylor-series engine.
- Accepts tagged (func, x) requests on a valid/ready interface and buffers them in a small FIFO.
- Issues requests to the engine one at a time over its start/busy handshake, holding func stable for the whole computation.
- Returns each result (integer part, fractional part, tag, error flag) on a valid/ready response interface, with timeout detection.

Parameters:
F_WIDTH, 8, fractional width of x and of the result fraction (matches engine)
TAG_WIDTH, 4, width of the request/response tag
FIFO_DEPTH, 4, request FIFO entries (power of two, >=2)
INIT_CYCLES, 2, cycles after rst deassertion before the first start is allowed
BUSY_WAIT, 3, max cycles after start for eng_busy to rise
TIMEOUT, 63, max cycles eng_busy may stay high
TO_WIDTH, 6, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset; also driven to the engine reset
req_valid  input  1  request present
req_ready  output  1  FIFO not full
req_func  input  2  function select
req_x  input  F_WIDTH  operand
req_tag  input  TAG_WIDTH  caller tag
eng_start  output  1  engine start pulse
eng_func  output  2  engine func, held for the whole operation
eng_x  output  F_WIDTH  engine operand
eng_busy  input  1  engine busy
eng_ipart  input  2  engine integer result
eng_fpart  input  F_WIDTH  engine fractional result
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts
rsp_ipart  output  2  captured integer part
rsp_fpart  output  F_WIDTH  captured fraction
rsp_tag  output  TAG_WIDTH  tag of the request
rsp_err  output  1  1 = timeout; the result fields are then 0
fifo_count  output  clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
Reset:
- Synchronous, active-high, on clk.
- On reset, all of these outputs are 0: eng_start, eng_func, eng_x, rsp_*, fifo_count.
- The FIFO is emptied, the state goes to INIT, and the counters clear.
- Reset mid-operation abandons any in-flight request with no response.

FIFO:
- Push when req_valid && req_ready; req_ready = !full.
- Pop only on the ISSUE transition.
- Push and pop in the same cycle while full is not possible, since req_ready = 0 when full.
- Push and pop in the same cycle at any other occupancy leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM:
- INIT:
  - Count INIT_CYCLES, then go to IDLE.
  - This covers the engine's RESET to WAIT_ON_START step; eng_busy is ignored.
- IDLE: if the FIFO is non-empty and rsp_valid = 0, load eng_func/eng_x/tag from the head, pop, and go to ISSUE.
- ISSUE:
  - eng_start = 1 for exactly this one cycle.
  - Go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY:
  - eng_busy = 1 goes to WAIT_DONE with the counter cleared.
  - Counter reaching BUSY_WAIT goes to RESPOND with err = 1.
- WAIT_DONE:
  - eng_busy = 0 means the result is complete: capture eng_ipart/eng_fpart this cycle, err = 0, go to RESPOND.
  - Counter reaching TIMEOUT goes to RESPOND with err = 1.
- RESPOND:
  - rsp_valid = 1; the fields stay stable until rsp_ready.
  - On handshake, go to IDLE.
  - A new request is not issued in the same cycle; one bubble minimum.

Engine interface rules:
- eng_func and eng_x are held constant from ISSUE until the return to IDLE, because the engine samples func throughout the computation for add/sub alternation.
- eng_start is never asserted while eng_busy = 1.
- With the nominal engine (8 terms), the latency from start to busy falling is 1+4*8 = 33 busy cycles.
- Response is available 2 cycles after busy falls or earlier; the specified capture is on the first busy-low cycle.

Timeouts and abnormal engine behaviour:
- Timeouts never stall the driver.
- After an error, the driver pulses nothing extra; the next request is issued normally.
- eng_busy glitching high while in IDLE is ignored.

Test Plan:
- Reset then single request:
  - Stimulus: rst high 3 cycles; push func=2'b01, x=8'h40, tag=3; engine model busy for 33 cycles, then ipart=2'b01, fpart=8'h5A.
  - Required: no start during the 2 INIT cycles; exactly one start pulse; eng_func=01 held throughout; rsp = {01, 5A, tag 3, err 0}.
- Back-to-back:
  - Stimulus: push 5 requests with tags 0..4 while the engine is busy.
  - Required: req_ready drops after 4 entries; responses arrive in order with tags 0..4; no start overlaps busy.
- Response backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid -> fields stable, no new start, FIFO holds the remaining requests.
- Busy never rises: engine model ignores start -> after BUSY_WAIT=3 cycles, rsp_err=1 with ipart/fpart=0; the next request proceeds normally.
- Busy stuck high: hold eng_busy=1 -> rsp_err=1 after 63 busy cycles.
- Reset mid-operation: assert rst during WAIT_DONE -> the in-flight request is dropped with no response, fifo_count=0, and the INIT delay is re-applied.
